// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN output readout stage.
package snn_pkg;

  // Readout sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StCollect,
    StDone
  } collector_state_t;

  // Address width for n entries; never narrower than one bit.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_output_collector_if.sv
// Write port of the output spike-count RAM.
interface snn_output_collector_if #(
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned COUNT_WIDTH = 32
);

  logic                   ram_wen;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [COUNT_WIDTH-1:0] ram_din;

  modport master (output ram_wen, ram_addr, ram_din);
  modport slave  (input  ram_wen, ram_addr, ram_din);

endinterface

// File: rtl/snn_argmax_acc.sv
// Running argmax over a stream of (index, value) pairs; lowest index wins ties.
module snn_argmax_acc #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned IDX_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   en,
  input  logic [COUNT_WIDTH-1:0] value,
  input  logic [IDX_WIDTH-1:0]   index,
  output logic [IDX_WIDTH-1:0]   max_idx,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   tie
);

  logic [IDX_WIDTH-1:0]   max_idx_q;
  logic [COUNT_WIDTH-1:0] max_count_q;
  logic                   tie_q;

  // Strict greater-than keeps the first index holding the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q   <= '0;
      max_count_q <= '0;
      tie_q       <= 1'b0;
    end else if (clear) begin
      max_idx_q   <= '0;
      max_count_q <= '0;
      tie_q       <= 1'b0;
    end else if (en) begin
      if (value > max_count_q) begin
        max_idx_q   <= index;
        max_count_q <= value;
        tie_q       <= 1'b0;
      end else if ((value == max_count_q) && (max_count_q != '0)) begin
        tie_q <= 1'b1;
      end
    end
  end

  assign max_idx   = max_idx_q;
  assign max_count = max_count_q;
  assign tie       = tie_q;

endmodule

// File: rtl/snn_output_collector.sv
// Snapshots output spike counts at network completion, streams them into the
// output RAM one per clock, and reports the winning neuron.
module snn_output_collector
  import snn_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned COUNT_WIDTH = 32,
  localparam int unsigned ADDR_WIDTH = addr_bits(NUM_OUTPUTS)
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic                               network_start,
  input  logic                               network_done,
  input  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_counts,
  snn_output_collector_if.master             ram,
  output logic                               busy,
  output logic                               done,
  output logic [ADDR_WIDTH-1:0]              winner_idx,
  output logic [COUNT_WIDTH-1:0]             winner_count,
  output logic                               winner_valid,
  output logic                               tie
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_OUTPUTS - 1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  collector_state_t       state_q, state_d;
  logic [COUNT_WIDTH-1:0] snap_q [NUM_OUTPUTS];
  logic                   capture;
  logic                   ram_wen_q, ram_wen_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [COUNT_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                   done_q, done_d;

  // Reset asserts immediately, releases two clocks after the external deassert.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Next-state and write-port sequencing; ram_addr doubles as the index counter.
  always_comb begin
    state_d    = state_q;
    ram_wen_d  = ram_wen_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    done_d     = done_q;
    capture    = 1'b0;
    if (network_start) begin
      state_d   = StArm;
      ram_wen_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        // network_done here is left over from the previous run.
        StArm: state_d = StRun;
        StRun: begin
          if (network_done) begin
            capture    = 1'b1;
            state_d    = StCollect;
            ram_wen_d  = 1'b1;
            ram_addr_d = '0;
            ram_din_d  = spike_counts[0 +: COUNT_WIDTH];
          end
        end
        StCollect: begin
          if (ram_addr_q == LastIdx) begin
            state_d   = StDone;
            ram_wen_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
            ram_din_d  = snap_q[ram_addr_d];
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and write-port registers.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ram_wen_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_wen_q  <= ram_wen_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      done_q     <= done_d;
    end
  end

  // Snapshot of all counters, taken only in the completion cycle.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
        snap_q[i] <= spike_counts[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // Winner tracks exactly the words presented to the RAM.
  snn_argmax_acc #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .IDX_WIDTH   (ADDR_WIDTH)
  ) u_argmax (
    .clk       (S_AXI_ACLK),
    .rst_n     (rst_n),
    .clear     (network_start),
    .en        (ram_wen_q),
    .value     (ram_din_q),
    .index     (ram_addr_q),
    .max_idx   (winner_idx),
    .max_count (winner_count),
    .tie       (tie)
  );

  assign ram.ram_wen   = ram_wen_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_din   = ram_din_q;
  assign busy          = (state_q == StArm) || (state_q == StRun) || (state_q == StCollect);
  assign done          = done_q;
  assign winner_valid  = (winner_count != '0);

endmodule

// File: tb/tb_snn_output_collector.sv
// Randomized self-checking bench for snn_output_collector against an argmax model.
module tb_snn_output_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned AW = 2;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              network_start;
  logic              network_done;
  logic [N*CW-1:0]   spike_counts;
  logic              busy, done, winner_valid, tie;
  logic [AW-1:0]     winner_idx;
  logic [CW-1:0]     winner_count;

  logic [CW-1:0]     exp_cnt [N];
  logic [AW-1:0]     exp_idx;
  logic [CW-1:0]     exp_max;
  logic              exp_tie;

  int n_checks = 0;
  int n_fail   = 0;

  snn_output_collector_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) ram_bus ();

  snn_output_collector #(
    .NUM_OUTPUTS (N),
    .COUNT_WIDTH (CW)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (arst_n),
    .network_start (network_start),
    .network_done  (network_done),
    .spike_counts  (spike_counts),
    .ram           (ram_bus),
    .busy          (busy),
    .done          (done),
    .winner_idx    (winner_idx),
    .winner_count  (winner_count),
    .winner_valid  (winner_valid),
    .tie           (tie)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: largest value, first index holding it, tie if it occurs twice and is nonzero.
  task automatic model();
    int hits;
    exp_max = '0;
    for (int i = 0; i < int'(N); i++) if (exp_cnt[i] > exp_max) exp_max = exp_cnt[i];
    exp_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) if (exp_cnt[i] == exp_max) exp_idx = AW'(i);
    hits = 0;
    for (int i = 0; i < int'(N); i++) if (exp_cnt[i] == exp_max) hits++;
    exp_tie = (hits > 1) && (exp_max != '0);
  endtask

  task automatic drive_counts();
    for (int i = 0; i < int'(N); i++) spike_counts[i*CW +: CW] = exp_cnt[i];
  endtask

  // Start, hold ARM/RUN, then complete; returns with write 0 on the bus.
  task automatic start_and_capture(input bit stale);
    network_done  = stale;
    network_start = 1'b1;
    step();
    network_start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done", done, 0);
    check("arm_wen", ram_bus.ram_wen, 0);
    check("arm_winner_count", winner_count, 0);
    check("arm_tie", tie, 0);
    check("arm_valid", winner_valid, 0);
    drive_counts();
    step();
    check("run_wen", ram_bus.ram_wen, 0);
    check("run_busy", busy, 1);
    network_done = 1'b1;
    step();
  endtask

  task automatic collect_and_check(input bit isolate);
    network_done = 1'($urandom_range(0, 1));
    if (isolate) for (int i = 0; i < int'(N); i++) spike_counts[i*CW +: CW] = 32'd100;
    for (int k = 0; k < int'(N); k++) begin
      check("wr_wen", ram_bus.ram_wen, 1);
      check("wr_addr", ram_bus.ram_addr, k);
      check("wr_din", ram_bus.ram_din, exp_cnt[k]);
      check("wr_done", done, 0);
      step();
    end
    check("done_flag", done, 1);
    check("done_wen", ram_bus.ram_wen, 0);
    check("done_busy", busy, 0);
    check("winner_idx", winner_idx, exp_idx);
    check("winner_count", winner_count, exp_max);
    check("winner_valid", winner_valid, exp_max != 0);
    check("tie", tie, exp_tie);
    network_done = 1'b1;
    step();
    step();
    check("hold_done", done, 1);
    check("hold_wen", ram_bus.ram_wen, 0);
    check("hold_winner", winner_count, exp_max);
  endtask

  task automatic full_run(input bit stale, input bit isolate);
    model();
    start_and_capture(stale);
    collect_and_check(isolate);
  endtask

  initial begin
    arst_n        = 1'b0;
    network_start = 1'b0;
    network_done  = 1'b0;
    spike_counts  = '0;
    #3;
    check("rst_wen", ram_bus.ram_wen, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner_count, 0);
    repeat (2) step();
    arst_n = 1'b1;
    repeat (3) step();
    check("idle_wen", ram_bus.ram_wen, 0);

    // Directed patterns.
    exp_cnt = '{32'd3, 32'd9, 32'd1, 32'd4};
    full_run(1'b0, 1'b0);
    exp_cnt = '{32'd5, 32'd7, 32'd7, 32'd2};
    full_run(1'b1, 1'b0);
    exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
    full_run(1'b0, 1'b1);
    exp_cnt = '{32'd8, 32'd2, 32'd8, 32'd1};
    full_run(1'b1, 1'b1);

    // Abort after the second write: start lands while addr 1 is on the bus.
    exp_cnt = '{32'd11, 32'd22, 32'd33, 32'd44};
    model();
    start_and_capture(1'b0);
    check("abort_w0", ram_bus.ram_addr, 0);
    step();
    check("abort_w1", ram_bus.ram_addr, 1);
    check("abort_w1_wen", ram_bus.ram_wen, 1);
    network_start = 1'b1;
    step();
    network_start = 1'b0;
    network_done  = 1'b0;
    check("abort_wen", ram_bus.ram_wen, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 1);
    step();
    check("abort_run_wen", ram_bus.ram_wen, 0);
    check("abort_run_done", done, 0);
    full_run(1'b0, 1'b0);

    // Asynchronous reset in the middle of the write burst.
    exp_cnt = '{32'd6, 32'd5, 32'd4, 32'd3};
    model();
    start_and_capture(1'b0);
    step();
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_wen", ram_bus.ram_wen, 0);
    check("arst_addr", ram_bus.ram_addr, 0);
    check("arst_din", ram_bus.ram_din, 0);
    check("arst_busy", busy, 0);
    check("arst_winner", winner_count, 0);
    step();
    arst_n = 1'b1;
    network_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_wen", ram_bus.ram_wen, 0);
      check("post_rst_busy", busy, 0);
    end

    // Randomized runs, mixing tie-prone small values with full-range counts.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (r % 2 == 0) exp_cnt[i] = CW'($urandom_range(0, 3));
        else            exp_cnt[i] = $urandom;
      end
      full_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
